// File: rtl/game_control.sv
// Per-frame sequencer for the game datapath: drives one-hot phase strobes,
// waits on draw done flags with a watchdog, gates frames on run, counts frames.
module game_control #(
  parameter int unsigned  COLLIDE_CYCLES = 2,
  parameter logic [19:0]  DRAW_TIMEOUT   = 20'd200000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic        idle_done,
  input  logic        draw_map_done,
  input  logic        draw_link_done,
  input  logic        draw_enemies_done,
  output logic        init,
  output logic        idle,
  output logic        gen_move,
  output logic        check_collide,
  output logic        apply_act_link,
  output logic        move_enemies,
  output logic        draw_map,
  output logic        draw_link,
  output logic        draw_enemies,
  output logic [15:0] frame_count,
  output logic        timeout_err,
  output logic [3:0]  state_dbg
);

  localparam logic [3:0] S_RST    = 4'd0;
  localparam logic [3:0] S_INIT   = 4'd1;
  localparam logic [3:0] S_IDLE   = 4'd2;
  localparam logic [3:0] S_GEN    = 4'd3;
  localparam logic [3:0] S_COLL   = 4'd4;
  localparam logic [3:0] S_APPLY  = 4'd5;
  localparam logic [3:0] S_MOVE_E = 4'd6;
  localparam logic [3:0] S_DMAP   = 4'd7;
  localparam logic [3:0] S_DLINK  = 4'd8;
  localparam logic [3:0] S_DENEM  = 4'd9;

  logic [3:0]  state, state_nx;
  logic [3:0]  coll_cnt;
  logic [19:0] draw_cnt;
  logic        is_draw, draw_done, adv_done, adv_to, draw_adv;

  // Done is ignored on the first cycle of a draw state (stale-flag guard);
  // a done coinciding with the timeout wins, so no error is flagged.
  always_comb begin
    is_draw   = (state == S_DMAP) || (state == S_DLINK) || (state == S_DENEM);
    draw_done = 1'b0;
    case (state)
      S_DMAP:  draw_done = draw_map_done;
      S_DLINK: draw_done = draw_link_done;
      S_DENEM: draw_done = draw_enemies_done;
      default: draw_done = 1'b0;
    endcase
    adv_done = is_draw && (draw_cnt != 20'd0) && draw_done;
    adv_to   = is_draw && (draw_cnt == DRAW_TIMEOUT - 20'd1) && !adv_done;
    draw_adv = adv_done || adv_to;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_RST:    state_nx = S_INIT;
      S_INIT:   state_nx = S_IDLE;
      S_IDLE:   if (idle_done && run) state_nx = S_GEN;
      S_GEN:    state_nx = S_COLL;
      S_COLL:   if (coll_cnt == 4'd0) state_nx = S_APPLY;
      S_APPLY:  state_nx = S_MOVE_E;
      S_MOVE_E: state_nx = S_DMAP;
      S_DMAP:   if (draw_adv) state_nx = S_DLINK;
      S_DLINK:  if (draw_adv) state_nx = S_DENEM;
      S_DENEM:  if (draw_adv) state_nx = S_IDLE;
      default:  state_nx = S_RST;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_RST;
      coll_cnt    <= 4'd0;
      draw_cnt    <= 20'd0;
      frame_count <= 16'd0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_GEN)
        coll_cnt <= 4'(COLLIDE_CYCLES - 1);
      else if (state == S_COLL && coll_cnt != 4'd0)
        coll_cnt <= coll_cnt - 4'd1;
      // Counter restarts whenever the next cycle is the first of a state.
      if (is_draw && state_nx == state)
        draw_cnt <= draw_cnt + 20'd1;
      else
        draw_cnt <= 20'd0;
      if (adv_to)
        timeout_err <= 1'b1;
      if (state == S_DENEM && state_nx == S_IDLE)
        frame_count <= frame_count + 16'd1;
    end
  end

  always_comb begin
    init           = (state == S_INIT);
    idle           = (state == S_IDLE);
    gen_move       = (state == S_GEN);
    check_collide  = (state == S_COLL);
    apply_act_link = (state == S_APPLY);
    move_enemies   = (state == S_MOVE_E);
    draw_map       = (state == S_DMAP);
    draw_link      = (state == S_DLINK);
    draw_enemies   = (state == S_DENEM);
    state_dbg      = state;
  end

endmodule

// File: tb/tb_game_control.sv
// Directed bench for game_control with a short draw watchdog (16 cycles).
module tb_game_control;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic        idle_done = 1'b0;
  logic        draw_map_done = 1'b0;
  logic        draw_link_done = 1'b0;
  logic        draw_enemies_done = 1'b0;
  logic        init, idle, gen_move, check_collide, apply_act_link, move_enemies;
  logic        draw_map, draw_link, draw_enemies, timeout_err;
  logic [15:0] frame_count;
  logic [3:0]  state_dbg;
  logic [8:0]  strobes;

  int tests = 0;
  int fails = 0;

  game_control #(.COLLIDE_CYCLES(2), .DRAW_TIMEOUT(20'd16)) dut (
    .clock(clock), .reset(reset), .run(run), .idle_done(idle_done),
    .draw_map_done(draw_map_done), .draw_link_done(draw_link_done),
    .draw_enemies_done(draw_enemies_done),
    .init(init), .idle(idle), .gen_move(gen_move), .check_collide(check_collide),
    .apply_act_link(apply_act_link), .move_enemies(move_enemies),
    .draw_map(draw_map), .draw_link(draw_link), .draw_enemies(draw_enemies),
    .frame_count(frame_count), .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  assign strobes = {init, idle, gen_move, check_collide, apply_act_link,
                    move_enemies, draw_map, draw_link, draw_enemies};

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Count cycles spent in state s (bounded).
  task automatic hold_len(input logic [3:0] s, output int n);
    n = 0;
    while (state_dbg == s && n < 100) begin
      step();
      n++;
    end
  endtask

  // Run a draw state, raising its done flag from cycle index dly onward.
  task automatic draw_phase(input logic [3:0] s, input int dly, output int n);
    n = 0;
    while (state_dbg == s && n < 64) begin
      draw_map_done     = (s == 4'd7) && (n >= dly);
      draw_link_done    = (s == 4'd8) && (n >= dly);
      draw_enemies_done = (s == 4'd9) && (n >= dly);
      step();
      n++;
    end
    draw_map_done = 1'b0;
    draw_link_done = 1'b0;
    draw_enemies_done = 1'b0;
  endtask

  task automatic start_frame();
    idle_done = 1'b1;
    step();
    idle_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    run = 1'b1;
    step();
    tests++;
    if (state_dbg !== 4'd0 || strobes !== 9'd0) begin
      fails++;
      $display("FAIL reset_state: state=%0d strobes=%b, want state=0 strobes=0", state_dbg, strobes);
    end
    tests++;
    if (frame_count !== 16'd0 || timeout_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_counters: frame=%0d err=%b, want 0/0", frame_count, timeout_err);
    end
    reset = 1'b1;
    step();
    tests++;
    if (state_dbg !== 4'd1 || strobes !== 9'b100000000) begin
      fails++;
      $display("FAIL init_entry: state=%0d strobes=%b, want 1/100000000", state_dbg, strobes);
    end
    step();
    tests++;
    if (state_dbg !== 4'd2 || strobes !== 9'b010000000) begin
      fails++;
      $display("FAIL idle_entry: state=%0d strobes=%b, want 2/010000000", state_dbg, strobes);
    end
    step();
    tests++;
    if (state_dbg !== 4'd2) begin
      fails++;
      $display("FAIL idle_hold: state=%0d, want 2", state_dbg);
    end
  endtask

  task automatic test_frame();
    int n;
    start_frame();
    tests++;
    if (strobes !== 9'b001000000) begin
      fails++;
      $display("FAIL gen_strobe: strobes=%b, want 001000000", strobes);
    end
    hold_len(4'd3, n);
    tests++;
    if (n != 1) begin fails++; $display("FAIL gen_len: got %0d, want 1", n); end
    tests++;
    if (strobes !== 9'b000100000) begin
      fails++;
      $display("FAIL coll_strobe: strobes=%b, want 000100000", strobes);
    end
    hold_len(4'd4, n);
    tests++;
    if (n != 2) begin fails++; $display("FAIL coll_len: got %0d, want 2", n); end
    hold_len(4'd5, n);
    tests++;
    if (n != 1) begin fails++; $display("FAIL apply_len: got %0d, want 1", n); end
    tests++;
    if (strobes !== 9'b000001000) begin
      fails++;
      $display("FAIL move_strobe: strobes=%b, want 000001000", strobes);
    end
    hold_len(4'd6, n);
    tests++;
    if (n != 1) begin fails++; $display("FAIL move_len: got %0d, want 1", n); end
    tests++;
    if (strobes !== 9'b000000100) begin
      fails++;
      $display("FAIL dmap_strobe: strobes=%b, want 000000100", strobes);
    end
    draw_phase(4'd7, 4, n);
    tests++;
    if (n != 5) begin fails++; $display("FAIL dmap_len: got %0d, want 5", n); end
    tests++;
    if (strobes !== 9'b000000010) begin
      fails++;
      $display("FAIL dlink_strobe: strobes=%b, want 000000010", strobes);
    end
    draw_phase(4'd8, 4, n);
    tests++;
    if (n != 5) begin fails++; $display("FAIL dlink_len: got %0d, want 5", n); end
    tests++;
    if (strobes !== 9'b000000001) begin
      fails++;
      $display("FAIL denem_strobe: strobes=%b, want 000000001", strobes);
    end
    draw_phase(4'd9, 4, n);
    tests++;
    if (n != 5) begin fails++; $display("FAIL denem_len: got %0d, want 5", n); end
    tests++;
    if (state_dbg !== 4'd2 || frame_count !== 16'd1 || timeout_err !== 1'b0) begin
      fails++;
      $display("FAIL frame_end: state=%0d frame=%0d err=%b, want 2/1/0", state_dbg, frame_count, timeout_err);
    end
  endtask

  task automatic to_draw();
    int n;
    start_frame();
    hold_len(4'd3, n);
    hold_len(4'd4, n);
    hold_len(4'd5, n);
    hold_len(4'd6, n);
  endtask

  task automatic test_draw_min();
    int n;
    to_draw();
    draw_phase(4'd7, 0, n);
    tests++;
    if (n != 2) begin fails++; $display("FAIL dmap_min_len: got %0d, want 2", n); end
    draw_phase(4'd8, 1, n);
    tests++;
    if (n != 2) begin fails++; $display("FAIL dlink_min_len: got %0d, want 2", n); end
    draw_phase(4'd9, 3, n);
    tests++;
    if (frame_count !== 16'd2 || timeout_err !== 1'b0) begin
      fails++;
      $display("FAIL frame2: frame=%0d err=%b, want 2/0", frame_count, timeout_err);
    end
  endtask

  task automatic test_timeout();
    int n;
    to_draw();
    draw_phase(4'd7, 15, n);
    tests++;
    if (n != 16 || timeout_err !== 1'b0) begin
      fails++;
      $display("FAIL done_at_limit: len=%0d err=%b, want 16/0", n, timeout_err);
    end
    draw_phase(4'd8, 99, n);
    tests++;
    if (n != 16) begin fails++; $display("FAIL dlink_timeout_len: got %0d, want 16", n); end
    tests++;
    if (timeout_err !== 1'b1 || state_dbg !== 4'd9) begin
      fails++;
      $display("FAIL timeout_flag: err=%b state=%0d, want 1/9", timeout_err, state_dbg);
    end
    draw_phase(4'd9, 4, n);
    tests++;
    if (timeout_err !== 1'b1 || frame_count !== 16'd3 || state_dbg !== 4'd2) begin
      fails++;
      $display("FAIL timeout_sticky: err=%b frame=%0d state=%0d, want 1/3/2", timeout_err, frame_count, state_dbg);
    end
  endtask

  task automatic test_pause();
    run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idle_done = 1'b1;
      step();
      idle_done = 1'b0;
      step();
    end
    tests++;
    if (state_dbg !== 4'd2) begin
      fails++;
      $display("FAIL pause_hold: state=%0d, want 2", state_dbg);
    end
    run = 1'b1;
    step();
    tests++;
    if (state_dbg !== 4'd2) begin
      fails++;
      $display("FAIL resume_waits_tick: state=%0d, want 2", state_dbg);
    end
    start_frame();
    tests++;
    if (state_dbg !== 4'd3) begin
      fails++;
      $display("FAIL resume_gen: state=%0d, want 3", state_dbg);
    end
    // Dropping run mid-frame must not stall the frame.
    run = 1'b0;
    step();
    tests++;
    if (state_dbg !== 4'd4) begin
      fails++;
      $display("FAIL run_low_midframe: state=%0d, want 4", state_dbg);
    end
    run = 1'b1;
  endtask

  task automatic test_reset_midframe();
    int n;
    hold_len(4'd4, n);
    hold_len(4'd5, n);
    hold_len(4'd6, n);
    draw_phase(4'd7, 2, n);
    draw_phase(4'd8, 2, n);
    step();
    #2;
    reset = 1'b0;
    #1;
    tests++;
    if (strobes !== 9'd0 || state_dbg !== 4'd0 || frame_count !== 16'd0 || timeout_err !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: strobes=%b state=%0d frame=%0d err=%b, want 0/0/0/0",
               strobes, state_dbg, frame_count, timeout_err);
    end
    step();
    reset = 1'b1;
    step();
    tests++;
    if (init !== 1'b1 || state_dbg !== 4'd1 || frame_count !== 16'd0) begin
      fails++;
      $display("FAIL reinit: init=%b state=%0d frame=%0d, want 1/1/0", init, state_dbg, frame_count);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_draw_min();
    test_timeout();
    test_pause();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
